// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte link (transmitter and receiver).
package serial_pkg;

  localparam int BYTE_W       = 8;
  localparam int BUSY_TIMEOUT = 4;
  localparam int BIT_IDX_W    = $clog2(BYTE_W);
  localparam int TOUT_W       = $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    WAIT_BUSY,
    WAIT_FREE
  } state_t;

endpackage

// File: rtl/serializador_tx.sv
// Byte-to-serial transmitter: one-byte holding buffer, 9-cycle framed strobe
// (arming cycle + 8 LSB-first bits), then a handshake on the receiver busy flag.
module serializador_tx
  import serial_pkg::*;
(
  input  logic              clock_100KHz,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              status_in,
  output logic              write_out,
  output logic              data_out,
  output logic              busy_out,
  output logic [7:0]        bytes_sent,
  output logic              timeout_flag
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(BYTE_W - 1);
  localparam logic [TOUT_W-1:0]    LAST_TOUT = TOUT_W'(BUSY_TIMEOUT - 1);

  state_t                state, state_nxt;
  logic                  holding_full;
  logic [BYTE_W-1:0]     holding_reg;
  logic [BYTE_W-1:0]     shift_reg;
  logic [BIT_IDX_W-1:0]  bit_idx, bit_nxt, bit_inc;
  logic [TOUT_W-1:0]     tout_cnt, tout_nxt;
  logic                  write_nxt, data_nxt;
  logic                  accept, load, frame_done, timeout_hit;

  assign byte_ready = ~holding_full;
  assign busy_out   = (state != IDLE) | holding_full;
  assign accept     = byte_valid & ~holding_full;
  assign bit_inc    = bit_idx + BIT_IDX_W'(1);

  // write_out/data_out are registered from the next-state decode, so they
  // line up cycle-for-cycle with START/SEND without a combinational path.
  always_comb begin
    state_nxt   = state;
    bit_nxt     = bit_idx;
    tout_nxt    = tout_cnt;
    write_nxt   = 1'b0;
    data_nxt    = 1'b0;
    load        = 1'b0;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (holding_full && !status_in) begin
          load      = 1'b1;
          state_nxt = START;
          write_nxt = 1'b1;
        end
      end
      START: begin
        state_nxt = SEND;
        bit_nxt   = '0;
        write_nxt = 1'b1;
        data_nxt  = shift_reg[0];
      end
      SEND: begin
        if (bit_idx == LAST_BIT) begin
          state_nxt  = WAIT_BUSY;
          frame_done = 1'b1;
          tout_nxt   = '0;
        end else begin
          bit_nxt   = bit_inc;
          write_nxt = 1'b1;
          data_nxt  = shift_reg[bit_inc];
        end
      end
      WAIT_BUSY: begin
        if (status_in) begin
          state_nxt = WAIT_FREE;
        end else if (tout_cnt == LAST_TOUT) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end else begin
          tout_nxt = tout_cnt + TOUT_W'(1);
        end
      end
      WAIT_FREE: begin
        if (!status_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_100KHz) begin
    if (!reset) begin
      state        <= IDLE;
      write_out    <= 1'b0;
      data_out     <= 1'b0;
      holding_full <= 1'b0;
      bit_idx      <= '0;
      tout_cnt     <= '0;
      bytes_sent   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state     <= state_nxt;
      write_out <= write_nxt;
      data_out  <= data_nxt;
      bit_idx   <= bit_nxt;
      tout_cnt  <= tout_nxt;
      // accept needs an empty buffer and load needs a full one: never both
      if (accept) holding_full <= 1'b1;
      else if (load) holding_full <= 1'b0;
      if (frame_done) bytes_sent <= bytes_sent + 8'd1;
      if (timeout_hit) timeout_flag <= 1'b1;
    end
  end

  // Byte storage carries no reset; validity lives in holding_full and state.
  always_ff @(posedge clock_100KHz) begin
    if (accept) holding_reg <= byte_in;
    if (load) shift_reg <= holding_reg;
  end

endmodule

// File: tb/tb_serializador_tx.sv
// Bench for serializador_tx with a behavioural receiver and byte scoreboard.
module tb_serializador_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       status_in = 1'b0;
  logic       write_out;
  logic       data_out;
  logic       busy_out;
  logic [7:0] bytes_sent;
  logic       timeout_flag;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  bit   ack_en    = 1'b1;
  int   ack_delay = 3;
  int   ack_cnt   = 0;
  int   wcnt      = 0;
  int   lowcnt    = 1000;
  int   frames_seen = 0;
  int   partial   = 0;
  int   overlap_err = 0;
  int   gap_err   = 0;
  int   start_err = 0;
  int   idle_data_err = 0;
  logic [7:0] rx_sh = 8'h00;

  serializador_tx dut (
    .clock_100KHz (clk),
    .reset        (reset),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .status_in    (status_in),
    .write_out    (write_out),
    .data_out     (data_out),
    .busy_out     (busy_out),
    .bytes_sent   (bytes_sent),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  // Receiver model: arming cycle, 8 LSB-first bits, then busy for ack_delay cycles.
  always @(negedge clk) begin
    logic st_prev;
    st_prev = status_in;
    if (status_in) begin
      if (ack_cnt <= 1) status_in = 1'b0;
      else ack_cnt = ack_cnt - 1;
    end
    if (write_out === 1'b1) begin
      if (wcnt == 0) begin
        if (st_prev) overlap_err++;
        if (frames_seen > 0 && lowcnt < 2) gap_err++;
        if (data_out !== 1'b0) start_err++;
      end else if (wcnt <= 8) begin
        rx_sh[3'(wcnt - 1)] = data_out;
      end
      wcnt++;
      lowcnt = 0;
    end else begin
      if (wcnt == 9) begin
        rx_q.push_back(rx_sh);
        frames_seen++;
        if (ack_en) begin
          status_in = 1'b1;
          ack_cnt   = ack_delay;
        end
      end else if (wcnt != 0) begin
        partial++;
      end
      wcnt = 0;
      if (lowcnt < 1000) lowcnt++;
      if (data_out === 1'b1) idle_data_err++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (byte_ready === 1'b1) begin
        exp_q.push_back(b);
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (busy_out === 1'b0 && status_in == 1'b0 && write_out === 1'b0 && wcnt == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) tick();
    tests++; if (write_out !== 1'b0) begin fails++; $display("FAIL reset_write_out got %b want 0", write_out); end
    tests++; if (data_out !== 1'b0) begin fails++; $display("FAIL reset_data_out got %b want 0", data_out); end
    tests++; if (byte_ready !== 1'b1) begin fails++; $display("FAIL reset_byte_ready got %b want 1", byte_ready); end
    tests++; if (busy_out !== 1'b0) begin fails++; $display("FAIL reset_busy_out got %b want 0", busy_out); end
    tests++; if (bytes_sent !== 8'd0) begin fails++; $display("FAIL reset_bytes_sent got %0d want 0", bytes_sent); end
    tests++; if (timeout_flag !== 1'b0) begin fails++; $display("FAIL reset_timeout_flag got %b want 0", timeout_flag); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_a5();
    bit ok;
    logic [7:0] bits;
    logic [7:0] got, want;
    int highs;
    ack_en = 1'b1; ack_delay = 3;
    offer(8'hA5, ok);
    tests++; if (!ok) begin fails++; $display("FAIL a5_accept got timeout want accepted"); end
    tests++; if (write_out !== 1'b0 || byte_ready !== 1'b0 || busy_out !== 1'b1) begin
      fails++; $display("FAIL a5_t1 got wr=%b rdy=%b busy=%b want 0 0 1", write_out, byte_ready, busy_out);
    end
    tick();
    tests++; if (write_out !== 1'b1 || data_out !== 1'b0) begin
      fails++; $display("FAIL a5_start got wr=%b d=%b want 1 0", write_out, data_out);
    end
    highs = 1; bits = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (write_out === 1'b1) highs++;
      bits[i] = data_out;
    end
    tests++; if (bits !== 8'hA5) begin fails++; $display("FAIL a5_serial_bits got %h want a5", bits); end
    tick();
    tests++; if (write_out !== 1'b0 || highs != 9) begin
      fails++; $display("FAIL a5_strobe_len got wr=%b highs=%0d want 0 9", write_out, highs);
    end
    tests++; if (bytes_sent !== 8'd1) begin fails++; $display("FAIL a5_bytes_sent got %0d want 1", bytes_sent); end
    wait_idle(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL a5_idle got busy want idle"); end
    while (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      tests++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL a5_rx_extra got %h want none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin fails++; $display("FAIL a5_rx got %h want %h", got, want); end
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL a5_rx_missing got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] got, want;
    int ready_seen;
    ack_en = 1'b1; ack_delay = 3;
    offer(8'h01, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_accept1 got timeout want accepted"); end
    offer(8'hFF, ok);
    tests++; if (!ok || write_out !== 1'b1) begin
      fails++; $display("FAIL b2b_accept2_in_frame got ok=%b wr=%b want 1 1", ok, write_out);
    end
    tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL b2b_full got rdy=%b want 0", byte_ready); end
    byte_in = 8'hEE; byte_valid = 1'b1; ready_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (byte_ready !== 1'b0) ready_seen++;
    end
    byte_valid = 1'b0;
    tests++; if (ready_seen != 0) begin fails++; $display("FAIL b2b_ready_held got %0d want 0", ready_seen); end
    wait_idle(300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_idle got busy want idle"); end
    tests++; if (rx_q.size() != 2) begin fails++; $display("FAIL b2b_frames got %0d want 2", rx_q.size()); end
    while (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      tests++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_rx_extra got %h want none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin fails++; $display("FAIL b2b_rx got %h want %h", got, want); end
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_rx_missing got %0d left want 0", exp_q.size()); exp_q.delete(); end
    tests++; if (bytes_sent !== 8'd3) begin fails++; $display("FAIL b2b_bytes_sent got %0d want 3", bytes_sent); end
  endtask

  task automatic test_timeout();
    bit ok, seen;
    logic [7:0] got, want;
    ack_en = 1'b0;
    offer(8'h3C, ok);
    tests++; if (!ok) begin fails++; $display("FAIL to_accept got timeout want accepted"); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin if (write_out === 1'b1) seen = 1'b1; else tick(); end
    for (int i = 0; i < 20 && seen; i++) begin if (write_out === 1'b0) break; tick(); end
    tests++; if (!seen || write_out !== 1'b0 || timeout_flag !== 1'b0) begin
      fails++; $display("FAIL to_fall got seen=%b wr=%b flag=%b want 1 0 0", seen, write_out, timeout_flag);
    end
    repeat (3) tick();
    tests++; if (timeout_flag !== 1'b0) begin fails++; $display("FAIL to_early got %b want 0 at 3 cycles", timeout_flag); end
    tick();
    tests++; if (timeout_flag !== 1'b1 || busy_out !== 1'b0) begin
      fails++; $display("FAIL to_flag got flag=%b busy=%b want 1 0 at 4 cycles", timeout_flag, busy_out);
    end
    ack_en = 1'b1;
    offer(8'h5A, ok);
    wait_idle(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL to_next_idle got busy want idle"); end
    while (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      tests++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL to_rx_extra got %h want none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin fails++; $display("FAIL to_rx got %h want %h", got, want); end
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL to_rx_missing got %0d left want 0", exp_q.size()); exp_q.delete(); end
    tests++; if (timeout_flag !== 1'b1) begin fails++; $display("FAIL to_sticky got %b want 1", timeout_flag); end
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    int part0, highs;
    ack_en = 1'b1; ack_delay = 3;
    offer(8'hC3, ok);
    offer(8'h99, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rm_accept got timeout want accepted"); end
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wcnt == 6) begin hit = 1'b1; break; end
      tick();
    end
    tests++; if (!hit) begin fails++; $display("FAIL rm_reach_send5 got timeout want 5th bit"); end
    part0 = partial;
    reset = 1'b0;
    tick();
    tests++; if (write_out !== 1'b0 || byte_ready !== 1'b1) begin
      fails++; $display("FAIL rm_outputs got wr=%b rdy=%b want 0 1", write_out, byte_ready);
    end
    tests++; if (bytes_sent !== 8'd0 || timeout_flag !== 1'b0) begin
      fails++; $display("FAIL rm_counters got sent=%0d flag=%b want 0 0", bytes_sent, timeout_flag);
    end
    reset = 1'b1;
    exp_q.delete();
    highs = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (write_out !== 1'b0) highs++; end
    tests++; if (highs != 0 || rx_q.size() != 0) begin
      fails++; $display("FAIL rm_discard got highs=%0d rx=%0d want 0 0", highs, rx_q.size());
    end
    tests++; if (partial != part0 + 1) begin fails++; $display("FAIL rm_partial got %0d want %0d", partial - part0, 1); end
    rx_q.delete();
  endtask

  task automatic test_wrap();
    bit ok;
    int bad, nrx;
    logic [7:0] got, want;
    ack_en = 1'b1; ack_delay = 1;
    bad = 0; nrx = 0;
    for (int i = 0; i < 256; i++) begin
      offer(8'(i), ok);
      if (!ok) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL wrap_accept got %0d stalls want 0", bad); end
    wait_idle(500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_idle got busy want idle"); end
    while (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      nrx++;
      tests++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL wrap_rx_extra got %h want none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin fails++; $display("FAIL wrap_rx got %h want %h", got, want); end
      end
    end
    tests++; if (nrx != 256) begin fails++; $display("FAIL wrap_count got %0d want 256", nrx); exp_q.delete(); end
    tests++; if (bytes_sent !== 8'd0) begin fails++; $display("FAIL wrap_bytes_sent got %0d want 0", bytes_sent); end
    tests++; if (timeout_flag !== 1'b0) begin fails++; $display("FAIL wrap_no_timeout got %b want 0", timeout_flag); end
  endtask

  task automatic test_protocol();
    tests++; if (overlap_err != 0) begin fails++; $display("FAIL proto_start_while_busy got %0d want 0", overlap_err); end
    tests++; if (gap_err != 0) begin fails++; $display("FAIL proto_gap got %0d want 0", gap_err); end
    tests++; if (start_err != 0) begin fails++; $display("FAIL proto_arming_bit got %0d want 0", start_err); end
    tests++; if (idle_data_err != 0) begin fails++; $display("FAIL proto_idle_data got %0d want 0", idle_data_err); end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
